// File: rtl/mem_access_stage_if.sv
// Data-memory / bridge bus between the M stage (master) and the memory side (slave).
// Handshake: bus_req is held high with stable we/addr/be/wdata until a rising edge samples bus_ack=1.
interface mem_access_stage_if;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ack;

  modport master (
    output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    input  bus_rdata, bus_ack
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    output bus_rdata, bus_ack
  );
endinterface

// File: rtl/mem_access_stage.sv
// MIPS M stage: E/M pipeline register, one bus transaction per legal load/store,
// load lane alignment/extension and address-exception detection.
module mem_access_stage #(
  parameter logic [31:0] DM_HI  = 32'h0000_2FFF,
  parameter logic [31:0] DEV_LO = 32'h0000_7F00,
  parameter logic [31:0] DEV_HI = 32'h0000_7F1F
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_E,
  input  logic [31:0] AO_E,
  input  logic [31:0] WD_E,
  input  logic [31:0] PC_E,
  input  logic [31:0] PCAdd8_E,
  input  logic [3:0]  memop_E,
  input  logic        flush_M,
  output logic        stall_M,
  output logic        valid_M,
  output logic [31:0] DMout_M,
  output logic [31:0] AO_M,
  output logic [31:0] PC_M,
  output logic [31:0] PCAdd8_M,
  output logic        exc_M,
  output logic [4:0]  exc_code_M,
  output logic        state_dbg,
  mem_access_stage_if.master bus
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;
  state_t state, state_nxt;

  logic        valid_r, flush_pend;
  logic [3:0]  memop_r;
  logic [31:0] wd_r, dmout_r;

  function automatic logic is_load(input logic [3:0] op);
    return (op >= 4'd1) && (op <= 4'd5);
  endfunction

  function automatic logic is_store(input logic [3:0] op);
    return (op >= 4'd6) && (op <= 4'd8);
  endfunction

  function automatic logic is_word(input logic [3:0] op);
    return (op == 4'd1) || (op == 4'd6);
  endfunction

  function automatic logic is_half(input logic [3:0] op);
    return (op == 4'd2) || (op == 4'd3) || (op == 4'd7);
  endfunction

  // Only word accesses may reach the device window; sub-word ops are DM-only.
  function automatic logic addr_ok(input logic [3:0] op, input logic [31:0] a);
    logic in_dm, in_dev;
    in_dm  = (a <= DM_HI);
    in_dev = (a >= DEV_LO) && (a <= DEV_HI);
    if (is_word(op))      return (a[1:0] == 2'b00) && (in_dm || in_dev);
    else if (is_half(op)) return !a[0] && in_dm;
    else                  return in_dm;
  endfunction

  function automatic logic [31:0] load_ext(input logic [3:0] op, input logic [1:0] a,
                                           input logic [31:0] rd);
    logic [31:0] sh;
    logic [15:0] half;
    sh   = rd >> {a, 3'b000};
    half = a[1] ? rd[31:16] : rd[15:0];
    case (op)
      4'd1:    return rd;
      4'd2:    return {{16{half[15]}}, half};
      4'd3:    return {16'h0000, half};
      4'd4:    return {{24{sh[7]}}, sh[7:0]};
      4'd5:    return {24'h000000, sh[7:0]};
      default: return 32'h0;
    endcase
  endfunction

  logic mem_E, start;
  assign mem_E = valid_E && !flush_M && (is_load(memop_E) || is_store(memop_E));
  assign start = mem_E && addr_ok(memop_E, AO_E);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = BUSY;
      BUSY:    if (bus.bus_ack) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    stall_M       = (state == BUSY);
    bus.bus_req   = (state == BUSY);
    bus.bus_we    = (state == BUSY) && is_store(memop_r);
    bus.bus_addr  = {AO_M[31:2], 2'b00};
    bus.bus_be    = 4'b0000;
    bus.bus_wdata = 32'h0;
    if (state == BUSY) begin
      if (is_word(memop_r)) begin
        bus.bus_be    = 4'b1111;
        bus.bus_wdata = wd_r;
      end else if (is_half(memop_r)) begin
        bus.bus_be    = AO_M[1] ? 4'b1100 : 4'b0011;
        bus.bus_wdata = {2{wd_r[15:0]}};
      end else begin
        bus.bus_be    = 4'b0001 << AO_M[1:0];
        bus.bus_wdata = {4{wd_r[7:0]}};
      end
    end
    valid_M    = valid_r && (state == IDLE);
    exc_M      = valid_M && (is_load(memop_r) || is_store(memop_r)) && !addr_ok(memop_r, AO_M);
    exc_code_M = exc_M ? (is_load(memop_r) ? 5'd4 : 5'd5) : 5'd0;
    DMout_M    = dmout_r;
    state_dbg  = (state == BUSY);
  end

  // A flush seen at any point while BUSY is remembered so the slot turns into a bubble at ack.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_r    <= 1'b0;
      memop_r    <= 4'd0;
      AO_M       <= 32'h0;
      wd_r       <= 32'h0;
      PC_M       <= 32'h0;
      PCAdd8_M   <= 32'h0;
      dmout_r    <= 32'h0;
      flush_pend <= 1'b0;
    end else if (state == IDLE) begin
      valid_r    <= valid_E && !flush_M;
      memop_r    <= (valid_E && !flush_M && memop_E <= 4'd8) ? memop_E : 4'd0;
      AO_M       <= AO_E;
      wd_r       <= WD_E;
      PC_M       <= PC_E;
      PCAdd8_M   <= PCAdd8_E;
      dmout_r    <= 32'h0;
      flush_pend <= 1'b0;
    end else begin
      if (flush_M) flush_pend <= 1'b1;
      if (bus.bus_ack) begin
        flush_pend <= 1'b0;
        if (flush_M || flush_pend) begin
          valid_r <= 1'b0;
          memop_r <= 4'd0;
          dmout_r <= 32'h0;
        end else begin
          dmout_r <= load_ext(memop_r, AO_M[1:0], bus.bus_rdata);
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: inputs driven and outputs sampled on the falling edge.
module tb_mem_access_stage;
  logic        clk, reset;
  logic        valid_E, flush_M;
  logic [31:0] AO_E, WD_E, PC_E, PCAdd8_E;
  logic [3:0]  memop_E;
  logic        stall_M, valid_M, exc_M, state_dbg;
  logic [31:0] DMout_M, AO_M, PC_M, PCAdd8_M;
  logic [4:0]  exc_code_M;
  int          checks = 0;
  int          errors = 0;

  mem_access_stage_if bus_if ();

  mem_access_stage dut (
    .clk(clk), .reset(reset), .valid_E(valid_E), .AO_E(AO_E), .WD_E(WD_E),
    .PC_E(PC_E), .PCAdd8_E(PCAdd8_E), .memop_E(memop_E), .flush_M(flush_M),
    .stall_M(stall_M), .valid_M(valid_M), .DMout_M(DMout_M), .AO_M(AO_M),
    .PC_M(PC_M), .PCAdd8_M(PCAdd8_M), .exc_M(exc_M), .exc_code_M(exc_code_M),
    .state_dbg(state_dbg), .bus(bus_if.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp_v);
    end
  endtask

  task automatic set_e(input logic v, input logic [3:0] op, input logic [31:0] ao,
                       input logic [31:0] wd, input logic [31:0] pc);
    valid_E  = v;
    memop_E  = op;
    AO_E     = ao;
    WD_E     = wd;
    PC_E     = pc;
    PCAdd8_E = pc + 32'd8;
  endtask

  task automatic nop_e();
    set_e(1'b0, 4'd0, 32'h0, 32'h0, 32'h0);
  endtask

  // Zero-wait load: one BUSY cycle, then the result is visible with valid_M=1.
  task automatic do_load(input string tag, input logic [3:0] op, input logic [31:0] ao,
                         input logic [31:0] rd, input logic [3:0] exp_be,
                         input logic [31:0] exp_dm);
    set_e(1'b1, op, ao, 32'h0, 32'h0000_3000 + ao);
    @(negedge clk);
    check({tag, " req"},   {31'h0, bus_if.bus_req}, 32'd1);
    check({tag, " we"},    {31'h0, bus_if.bus_we}, 32'd0);
    check({tag, " be"},    {28'h0, bus_if.bus_be}, {28'h0, exp_be});
    check({tag, " addr"},  bus_if.bus_addr, {ao[31:2], 2'b00});
    check({tag, " stall"}, {31'h0, stall_M}, 32'd1);
    check({tag, " vbusy"}, {31'h0, valid_M}, 32'd0);
    bus_if.bus_ack   = 1'b1;
    bus_if.bus_rdata = rd;
    nop_e();
    @(negedge clk);
    check({tag, " stall2"}, {31'h0, stall_M}, 32'd0);
    check({tag, " req2"},   {31'h0, bus_if.bus_req}, 32'd0);
    check({tag, " valid"},  {31'h0, valid_M}, 32'd1);
    check({tag, " dmout"},  DMout_M, exp_dm);
    check({tag, " exc"},    {31'h0, exc_M}, 32'd0);
    check({tag, " ao"},     AO_M, ao);
    check({tag, " pc"},     PC_M, 32'h0000_3000 + ao);
    check({tag, " pc8"},    PCAdd8_M, 32'h0000_3008 + ao);
    bus_if.bus_ack   = 1'b0;
    bus_if.bus_rdata = 32'h0;
  endtask

  task automatic do_exc(input string tag, input logic [3:0] op, input logic [31:0] ao,
                        input logic [4:0] code);
    set_e(1'b1, op, ao, 32'h1234_5678, 32'h0000_0100);
    @(negedge clk);
    check({tag, " exc"},   {31'h0, exc_M}, 32'd1);
    check({tag, " code"},  {27'h0, exc_code_M}, {27'h0, code});
    check({tag, " req"},   {31'h0, bus_if.bus_req}, 32'd0);
    check({tag, " stall"}, {31'h0, stall_M}, 32'd0);
    check({tag, " valid"}, {31'h0, valid_M}, 32'd1);
    check({tag, " dmout"}, DMout_M, 32'h0);
    nop_e();
  endtask

  initial begin
    reset = 1'b0;
    flush_M = 1'b0;
    nop_e();
    bus_if.bus_ack   = 1'b0;
    bus_if.bus_rdata = 32'h0;
    @(negedge clk);
    @(negedge clk);
    check("rst req",   {31'h0, bus_if.bus_req}, 32'd0);
    check("rst stall", {31'h0, stall_M}, 32'd0);
    check("rst valid", {31'h0, valid_M}, 32'd0);
    check("rst ao",    AO_M, 32'h0);
    check("rst be",    {28'h0, bus_if.bus_be}, 32'h0);
    check("rst state", {31'h0, state_dbg}, 32'd0);
    reset = 1'b1;
    @(negedge clk);

    do_load("lw",  4'd1, 32'h10, 32'hDEAD_BEEF, 4'b1111, 32'hDEAD_BEEF);
    do_load("lb",  4'd4, 32'h13, 32'h8012_3456, 4'b1000, 32'hFFFF_FF80);
    do_load("lbu", 4'd5, 32'h13, 32'h8012_3456, 4'b1000, 32'h0000_0080);
    do_load("lh",  4'd2, 32'h12, 32'h8012_3456, 4'b1100, 32'hFFFF_8012);
    do_load("lhu", 4'd3, 32'h0,  32'h8012_F456, 4'b0011, 32'h0000_F456);
    do_load("lbl", 4'd4, 32'h1,  32'h8012_3456, 4'b0010, 32'h0000_0034);
    do_load("dev", 4'd1, 32'h7F04, 32'h0000_0055, 4'b1111, 32'h0000_0055);

    // SH with three wait cycles: request held stable, W sees bubbles.
    set_e(1'b1, 4'd7, 32'h6, 32'h0000_ABCD, 32'h0000_0200);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("sh req",   {31'h0, bus_if.bus_req}, 32'd1);
      check("sh we",    {31'h0, bus_if.bus_we}, 32'd1);
      check("sh be",    {28'h0, bus_if.bus_be}, 32'hC);
      check("sh addr",  bus_if.bus_addr, 32'h4);
      check("sh wdata", bus_if.bus_wdata, 32'hABCD_ABCD);
      check("sh stall", {31'h0, stall_M}, 32'd1);
      check("sh valid", {31'h0, valid_M}, 32'd0);
      check("sh ao",    AO_M, 32'h6);
      nop_e();
    end
    bus_if.bus_ack = 1'b1;
    @(negedge clk);
    bus_if.bus_ack = 1'b0;
    check("sh stall2", {31'h0, stall_M}, 32'd0);
    check("sh valid2", {31'h0, valid_M}, 32'd1);
    check("sh dmout",  DMout_M, 32'h0);

    // SB lane replication, one wait cycle
    set_e(1'b1, 4'd8, 32'h2, 32'h0000_00A5, 32'h0000_0210);
    @(negedge clk);
    check("sb be",    {28'h0, bus_if.bus_be}, 32'h4);
    check("sb wdata", bus_if.bus_wdata, 32'hA5A5_A5A5);
    nop_e();
    bus_if.bus_ack = 1'b1;
    @(negedge clk);
    bus_if.bus_ack = 1'b0;
    check("sb valid", {31'h0, valid_M}, 32'd1);

    do_exc("lw mis",  4'd1, 32'h2,    5'd4);
    do_exc("sb oor",  4'd8, 32'h3000, 5'd5);
    do_exc("lh dev",  4'd2, 32'h7F04, 5'd4);
    do_exc("sw dev+", 4'd6, 32'h7F20, 5'd5);
    @(negedge clk);
    check("exc clr", {31'h0, exc_M}, 32'd0);

    // Flush arrives mid-transaction for one cycle only
    set_e(1'b1, 4'd6, 32'h20, 32'h1234_5678, 32'h0000_0300);
    @(negedge clk);
    check("fl wdata", bus_if.bus_wdata, 32'h1234_5678);
    check("fl be",    {28'h0, bus_if.bus_be}, 32'hF);
    flush_M = 1'b1;
    nop_e();
    @(negedge clk);
    check("fl req",   {31'h0, bus_if.bus_req}, 32'd1);
    check("fl stall", {31'h0, stall_M}, 32'd1);
    flush_M = 1'b0;
    bus_if.bus_ack = 1'b1;
    @(negedge clk);
    bus_if.bus_ack = 1'b0;
    check("fl valid", {31'h0, valid_M}, 32'd0);
    check("fl stall2", {31'h0, stall_M}, 32'd0);
    check("fl req2",  {31'h0, bus_if.bus_req}, 32'd0);

    // Flush at capture: no bus traffic
    set_e(1'b1, 4'd1, 32'h40, 32'h0, 32'h0000_0400);
    flush_M = 1'b1;
    @(negedge clk);
    flush_M = 1'b0;
    nop_e();
    check("fc req",   {31'h0, bus_if.bus_req}, 32'd0);
    check("fc valid", {31'h0, valid_M}, 32'd0);
    check("fc stall", {31'h0, stall_M}, 32'd0);

    // Async reset in the middle of BUSY
    set_e(1'b1, 4'd1, 32'h10, 32'h0, 32'h0000_0500);
    @(negedge clk);
    check("rb req",  {31'h0, bus_if.bus_req}, 32'd1);
    nop_e();
    #2 reset = 1'b0;
    #1;
    check("rb req0",   {31'h0, bus_if.bus_req}, 32'd0);
    check("rb stall0", {31'h0, stall_M}, 32'd0);
    check("rb ao0",    AO_M, 32'h0);
    check("rb pc0",    PC_M, 32'h0);
    check("rb pc80",   PCAdd8_M, 32'h0);
    check("rb addr0",  bus_if.bus_addr, 32'h0);
    check("rb state0", {31'h0, state_dbg}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    do_load("lw2", 4'd1, 32'h10, 32'hDEAD_BEEF, 4'b1111, 32'hDEAD_BEEF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- M-stage of the 5-stage MIPS pipeline: E/M pipeline register plus data-memory/bridge access, directly upstream of the M/W register.
- Captures E-stage results, issues one req/ack bus transaction per load/store, aligns/extends load data and flags address exceptions.
- Outputs DMout_M, AO_M, PC_M, PCAdd8_M feed the M/W register.
- Stalls upstream while a bus transaction is outstanding.

Parameters:
DM_HI, 32'h0000_2FFF, top byte address of data memory (DM occupies 0..DM_HI)
DEV_LO, 32'h0000_7F00, first byte address of device (timer) window
DEV_HI, 32'h0000_7F1F, last byte address of device window

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
valid_E  in  1  E slot holds a real instruction
AO_E  in  32  ALU result / effective address
WD_E  in  32  store data (forwarded rt)
PC_E  in  32  instruction PC
PCAdd8_E  in  32  PC+8 (link value)
memop_E  in  4  0 none, 1 LW, 2 LH, 3 LHU, 4 LB, 5 LBU, 6 SW, 7 SH, 8 SB; 9-15 treated as none
flush_M  in  1  kill instruction entering M (exception/eret)
stall_M  out  1  hold E and earlier stages
valid_M  out  1  M result valid for W capture
DMout_M  out  32  aligned, extended load data
AO_M  out  32  registered AO_E
PC_M  out  32  registered PC_E
PCAdd8_M  out  32  registered PCAdd8_E
exc_M  out  1  address exception on M instruction
exc_code_M  out  5  4 AdEL, 5 AdES, else 0
bus_req  out  1  transaction request
bus_we  out  1  1 store, 0 load
bus_addr  out  32  {AO_M[31:2],2'b00}
bus_be  out  4  byte enables, little-endian
bus_wdata  out  32  lane-replicated store data
bus_rdata  in  32  read data, valid with bus_ack
bus_ack  in  1  transaction complete, sampled at rising edge while bus_req=1

Behaviour:
- Reset (reset=0, async): all registers 0, state IDLE; all outputs 0; bus_req drops immediately; abandoned transaction is the bus side's problem.
- FSM: IDLE, BUSY.
- IDLE: at each edge, capture E inputs into M register; stall_M=0.
- flush_M=1 at capture: slot becomes bubble (valid=0, memop none).
- Captured valid memop, legal address -> BUSY.
- Legal address: aligned (LW/SW addr[1:0]=0; LH/LHU/SH addr[0]=0) and in [0,DM_HI], or word op in [DEV_LO,DEV_HI].
- Sub-word op to the device window, misalignment or out-of-range: exc_M=1, code 4 (loads) / 5 (stores); no bus access; stays IDLE; valid_M=1.
- BUSY: bus_req=1; bus_we/addr/be/wdata stable and derived from M register; stall_M=1; valid_M=0 (W captures a bubble); E inputs ignored.
- BUSY edge with bus_ack=1: latch extended load data into DMout register, -> IDLE. Min cost: one stall cycle per memory op.
- bus_ack while IDLE: ignored.
- Byte enables:
  - SW/LW: 1111.
  - SH/LH/LHU: addr[1] ? 1100 : 0011.
  - SB/LB/LBU: 0001 << addr[1:0].
- Store data: SH wdata={2{WD[15:0]}}; SB wdata={4{WD[7:0]}}.
- Loads: select lane by addr[1:0]; LB/LH sign-extend; LBU/LHU zero-extend.
- Non-load instructions: DMout_M=0.
- flush_M during BUSY: transaction still runs to ack (req never withdrawn); slot then becomes bubble, DMout discarded; stall_M held until ack.
- AO_M, PC_M, PCAdd8_M are pure registers (1-cycle latency from E); unchanged during BUSY.

Test Plan:
- LW AO_E=0x10, zero-wait ack -> bus_req one cycle, be=1111, addr=0x10; rdata 0xDEADBEEF -> DMout_M=0xDEADBEEF, valid_M=1 next cycle; stall_M high exactly 1 cycle.
- LB AO_E=0x13, rdata 0x80123456 -> be=1000, DMout_M=0xFFFFFF80. LBU same stimulus -> 0x00000080. LH at 0x12 -> 0xFFFF8012.
- SH AO_E=0x6, WD_E=0x0000ABCD, ack delayed 3 cycles -> bus_we=1, be=1100, wdata=0xABCDABCD held stable; stall_M high 3 cycles, valid_M=0 throughout.
- LW at 0x2, SB at 0x3000, LH at 0x7F04 -> exc_M=1, codes 4, 5, 4; bus_req never asserted; stall_M=0.
- flush_M during BUSY of SW 0x20 -> req held until ack, then valid_M=0. Separately, flush_M with LW at capture -> no bus_req.
- reset pulled low mid-BUSY -> bus_req, stall_M, all outputs 0 immediately; after release, next LW behaves as first scenario.
